// File: rtl/rect_grid_if.sv
// Rectangle-grid bus between the snake controller (master) and the grid
// memory (slave): write word, read port, clear/busy and render pixel port.
interface rect_grid_if;
  logic [35:0] rect_write;
  logic [31:0] rect_read_addr;
  logic [3:0]  rect_read_data;
  logic        clear;
  logic        busy;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic [3:0]  pix_cell;
  logic [10:0] pix_x_d;
  logic [10:0] pix_y_d;

  modport master (
    output rect_write, rect_read_addr, clear, pix_x, pix_y,
    input  rect_read_data, busy, pix_cell, pix_x_d, pix_y_d
  );

  modport slave (
    input  rect_write, rect_read_addr, clear, pix_x, pix_y,
    output rect_read_data, busy, pix_cell, pix_x_d, pix_y_d
  );
endinterface

// File: rtl/rect_grid_memory.sv
// Grid memory for the snake game: 32x24 cells of 4-bit codes, controller
// write/read port, 1-cycle render lookup and a clear sweep run after reset
// or on request.
module rect_grid_memory #(
  parameter int GRID_SIZE_X = 32,
  parameter int GRID_SIZE_Y = 24,
  parameter int RECT_SIZE_X = 32,
  parameter int RECT_SIZE_Y = 32,
  parameter int BORDER_ROCK = 0
) (
  input  logic       clk,
  input  logic       rst,
  rect_grid_if.slave bus
);

  localparam int XW    = $clog2(GRID_SIZE_X);
  localparam int YW    = $clog2(GRID_SIZE_Y);
  localparam int AW    = XW + YW;
  localparam int CELLS = GRID_SIZE_X * GRID_SIZE_Y;
  localparam int RXS   = $clog2(RECT_SIZE_X);
  localparam int RYS   = $clog2(RECT_SIZE_Y);

  localparam logic [3:0] C_NULL = 4'b0000;
  localparam logic [3:0] C_ROCK = 4'b0010;

  localparam logic [15:0]   GX16     = 16'(GRID_SIZE_X);
  localparam logic [15:0]   GY16     = 16'(GRID_SIZE_Y);
  localparam logic [10:0]   PIX_XMAX = 11'(GRID_SIZE_X * RECT_SIZE_X);
  localparam logic [10:0]   PIX_YMAX = 11'(GRID_SIZE_Y * RECT_SIZE_Y);
  localparam logic [XW-1:0] X_LAST   = XW'(GRID_SIZE_X - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(GRID_SIZE_Y - 1);
  localparam logic [AW-1:0] IDX_LAST = AW'(CELLS - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [3:0]  func;
  } rect_wr_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } rect_addr_t;

  logic [3:0] mem [0:CELLS-1];

  rect_wr_t   wr;
  rect_addr_t ra;
  logic [0:0]    state;
  logic [AW-1:0] clr_idx;
  logic          busy_q;

  logic          wr_in_range, rd_in_range, pix_in_range;
  logic [AW-1:0] wr_idx, rd_idx, pix_idx;
  logic [XW-1:0] clr_x;
  logic [YW-1:0] clr_y;
  logic          clr_border;
  logic          we;
  logic [AW-1:0] waddr;
  logic [3:0]    wdata;
  logic [3:0]    pix_cell_q;
  logic [10:0]   pix_x_q, pix_y_q;

  assign wr = bus.rect_write;
  assign ra = bus.rect_read_addr;

  // Full 16-bit compares so an underflowed 16'hFFFF lands out of range.
  assign wr_in_range  = (wr.x < GX16) && (wr.y < GY16);
  assign rd_in_range  = (ra.x < GX16) && (ra.y < GY16);
  assign pix_in_range = (bus.pix_x < PIX_XMAX) && (bus.pix_y < PIX_YMAX);

  // Row-major index; row stride is a power of two so it is a concatenation.
  assign wr_idx  = {wr.y[YW-1:0], wr.x[XW-1:0]};
  assign rd_idx  = {ra.y[YW-1:0], ra.x[XW-1:0]};
  assign pix_idx = {bus.pix_y[RYS +: YW], bus.pix_x[RXS +: XW]};

  assign clr_x      = clr_idx[XW-1:0];
  assign clr_y      = clr_idx[AW-1:XW];
  assign clr_border = (clr_x == '0) || (clr_x == X_LAST) ||
                      (clr_y == '0) || (clr_y == Y_LAST);

  // Clear sequencer: sweeps every cell once, restartable by clear or rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_idx <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.clear) begin
            state   <= S_CLEAR;
            clr_idx <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          if (bus.clear) begin
            clr_idx <= '0;
          end else if (clr_idx == IDX_LAST) begin
            state   <= S_IDLE;
            clr_idx <= '0;
            busy_q  <= 1'b0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
      endcase
    end
  end

  // Single write port: the sweep owns it while clearing, else the controller.
  always_comb begin
    we    = 1'b0;
    waddr = clr_idx;
    wdata = C_NULL;
    if (state == S_CLEAR) begin
      we    = 1'b1;
      wdata = ((BORDER_ROCK != 0) && clr_border) ? C_ROCK : C_NULL;
    end else if (wr_in_range) begin
      we    = 1'b1;
      waddr = wr_idx;
      wdata = wr.func;
    end
  end

  // Cell array; contents survive rst and are initialised by the sweep.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Zero-latency controller read; walls read as rock so they collide.
  always_comb begin
    bus.rect_read_data = C_ROCK;
    if (rd_in_range) bus.rect_read_data = mem[rd_idx];
  end

  // Render lookup with coordinates delayed alongside the cell code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cell_q <= '0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
    end else begin
      pix_cell_q <= pix_in_range ? mem[pix_idx] : C_NULL;
      pix_x_q    <= bus.pix_x;
      pix_y_q    <= bus.pix_y;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.pix_cell = pix_cell_q;
  assign bus.pix_x_d  = pix_x_q;
  assign bus.pix_y_d  = pix_y_q;

endmodule

// File: tb/tb_rect_grid_memory.sv
// Directed bench for rect_grid_memory with the rock border enabled.
module tb_rect_grid_memory;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cnt;

  rect_grid_if bus ();

  rect_grid_memory #(.BORDER_ROCK(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [35:0] WR_IDLE = {16'hFFFF, 16'hFFFF, 4'b0000};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] x, input logic [15:0] y, output logic [3:0] d);
    bus.rect_read_addr = {x, y};
    #1;
    d = bus.rect_read_data;
  endtask

  // Counts cycles with busy high, bounded so a stuck sweep still ends.
  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy && n < 2000) begin
      tick();
      n++;
    end
  endtask

  logic [3:0] d;

  initial begin
    bus.rect_write     = WR_IDLE;
    bus.rect_read_addr = '0;
    bus.clear          = 1'b0;
    bus.pix_x          = 11'd0;
    bus.pix_y          = 11'd0;

    // Reset state
    #12;
    chk("rst_busy", bus.busy, 1);
    chk("rst_pix_cell", bus.pix_cell, 0);
    chk("rst_pix_x_d", bus.pix_x_d, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: sweep length and cleared contents
    count_busy(cnt);
    chk("sweep_len", cnt, 768);
    rd(16'd5, 16'd7, d);    chk("clr_5_7", d, 4'b0000);
    rd(16'd0, 16'd0, d);    chk("border_0_0", d, 4'b0010);
    rd(16'd31, 16'd23, d);  chk("border_31_23", d, 4'b0010);
    rd(16'd31, 16'd0, d);   chk("border_31_0", d, 4'b0010);
    rd(16'd0, 16'd12, d);   chk("border_0_12", d, 4'b0010);
    rd(16'd1, 16'd1, d);    chk("clr_1_1", d, 4'b0000);
    rd(16'd30, 16'd22, d);  chk("clr_30_22", d, 4'b0000);

    // 2: write then read next cycle, render lookup
    bus.rect_write = {16'd15, 16'd15, 4'b0001};
    rd(16'd15, 16'd15, d);  chk("wr_before_edge", d, 4'b0000);
    tick();
    bus.rect_write = {16'd40, 16'd2, 4'b0100};   // out of range, x aliases 8
    rd(16'd15, 16'd15, d);  chk("wr_15_15", d, 4'b0001);
    bus.pix_x = 11'd480;
    bus.pix_y = 11'd480;
    tick();
    bus.rect_write = WR_IDLE;
    chk("pix_cell_480", bus.pix_cell, 4'b0001);
    chk("pix_x_d_480", bus.pix_x_d, 480);
    chk("pix_y_d_480", bus.pix_y_d, 480);

    // 3: out-of-range reads and discarded write
    rd(16'hFFFF, 16'd3, d); chk("oor_xneg", d, 4'b0010);
    rd(16'd32, 16'd0, d);   chk("oor_x32", d, 4'b0010);
    rd(16'd0, 16'd24, d);   chk("oor_y24", d, 4'b0010);
    rd(16'd8, 16'd2, d);    chk("oor_wr_alias", d, 4'b0000);

    // 5: read-during-write same cell
    bus.rect_write = {16'd10, 16'd4, 4'b0100};
    rd(16'd10, 16'd4, d);   chk("rdw_old", d, 4'b0000);
    tick();
    bus.rect_write = WR_IDLE;
    rd(16'd10, 16'd4, d);   chk("rdw_new", d, 4'b0100);

    // 6a: render out of range
    bus.pix_x = 11'd1100;
    bus.pix_y = 11'd100;
    tick();
    chk("pix_oor", bus.pix_cell, 4'b0000);
    chk("pix_x_d_1100", bus.pix_x_d, 1100);

    // 4: clear request, writes ignored while busy, restart mid-sweep
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clear_busy", bus.busy, 1);
    bus.rect_write = {16'd3, 16'd3, 4'b0100};
    for (int i = 0; i < 400; i++) tick();
    rd(16'd3, 16'd3, d);    chk("busy_wr_ign", d, 4'b0000);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    count_busy(cnt);
    chk("restart_len", cnt, 768);
    rd(16'd3, 16'd3, d);    chk("after_sweep_3_3", d, 4'b0000);
    bus.rect_write = WR_IDLE;
    rd(16'd15, 16'd15, d);  chk("reclr_15_15", d, 4'b0000);
    rd(16'd10, 16'd4, d);   chk("reclr_10_4", d, 4'b0000);

    // 6b: async reset mid-frame
    bus.rect_write = {16'd15, 16'd15, 4'b0001};
    tick();
    bus.rect_write = WR_IDLE;
    bus.pix_x = 11'd480;
    bus.pix_y = 11'd480;
    tick();
    chk("pre_rst_pix", bus.pix_cell, 4'b0001);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pix_cell", bus.pix_cell, 0);
    chk("arst_pix_x_d", bus.pix_x_d, 0);
    chk("arst_pix_y_d", bus.pix_y_d, 0);
    chk("arst_busy", bus.busy, 1);
    @(negedge clk);
    rst = 1'b0;
    count_busy(cnt);
    chk("rst_sweep_len", cnt, 768);
    rd(16'd15, 16'd15, d);  chk("rst_reclr", d, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_grid_memory.md
Name: rect_grid_memory

Overview:
- Responder end of the rectangle-grid interface driven by the snake game controller.
- Stores a 32x24 grid of 4-bit cell codes.
- Applies the controller's write word on every clock and answers its read address combinationally in the same cycle.
- Provides a 1-cycle registered render port that maps pixel coordinates to cell codes for the drawing pipeline, and a clear sequencer that sweeps the grid after reset or on request.

Parameters:
- GRID_SIZE_X, 32, cells per row; cell x in 0..31.
- GRID_SIZE_Y, 24, cells per column; cell y in 0..23.
- RECT_SIZE_X, 32, pixel width of one cell (1024/GRID_SIZE_X).
- RECT_SIZE_Y, 32, pixel height of one cell (768/GRID_SIZE_Y).
- BORDER_ROCK, 0, if 1 the clear sweep writes ROCK (4'b0010) into the outermost ring of cells instead of NULL.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- rect_write  input  36  {x[15:0], y[15:0], func[3:0]}; applied every cycle.
- rect_read_addr  input  32  {x[15:0], y[15:0]}; controller read address.
- rect_read_data  output  4  cell code at rect_read_addr; combinational.
- clear  input  1  single-cycle request to re-run the clear sweep.
- busy  output  1  high while the clear sweep runs.
- pix_x  input  11  render pixel x.
- pix_y  input  11  render pixel y.
- pix_cell  output  4  cell code for (pix_x, pix_y), registered.
- pix_x_d  output  11  pix_x delayed 1 cycle, aligned with pix_cell.
- pix_y_d  output  11  pix_y delayed 1 cycle, aligned with pix_cell.

Behaviour:
- Storage:
  - 768 x 4-bit array with linear index y*32 + x (x = low 5 bits, y = low 5 bits after the range check).
  - Synchronous write, asynchronous read.
  - Contents are not reset by rst; the clear sweep initialises them.
- Cell codes: NULL 0000, SNAKE 0001, ROCK 0010, SNACK 0100. Other codes are stored verbatim.
- Range check:
  - A coordinate is in range iff x[15:0] < GRID_SIZE_X and y[15:0] < GRID_SIZE_Y. The full 16 bits are compared, so 16'hFFFF (underflow from x=0 minus 1) is out of range.
- Write path:
  - Every cycle with busy=0 and rect_write in range, mem[idx] <= func at the clock edge.
  - An unchanged held word rewrites the same value, which is harmless.
  - Out-of-range writes are discarded.
  - All controller writes are discarded while busy=1.
- Read path:
  - rect_read_data = mem[idx(rect_read_addr)] combinationally, with zero latency, so a read address registered in cycle N is checked in cycle N+1.
  - Out-of-range address returns ROCK, which makes walls collide.
  - Reads are served during busy and return current array contents.
  - Read-during-write to the same cell returns the old value; the new value is visible the next cycle.
- Clear FSM, states IDLE and CLEAR:
  - rst asserted: state=CLEAR, clr_idx=0, busy=1, pix_cell=0, pix_x_d=0, pix_y_d=0.
  - CLEAR: each cycle write mem[clr_idx] <= (BORDER_ROCK && cell on border) ? ROCK : NULL, then clr_idx += 1.
  - After writing index 767, go to IDLE and set busy=0. The sweep lasts exactly 768 cycles.
  - IDLE: clear=1 moves to CLEAR with clr_idx=0; busy goes high the next cycle.
  - clear asserted during CLEAR restarts clr_idx at 0.
  - rst mid-sweep restarts the sweep.
- Render port:
  - pix_cell <= mem[(pix_y/RECT_SIZE_Y)*32 + pix_x/RECT_SIZE_X] when pix_x < 1024 and pix_y < 768, otherwise NULL.
  - pix_x_d <= pix_x and pix_y_d <= pix_y.
  - The divisions are shifts (pix_x[9:5], pix_y[9:5]).
  - Latency is 1 cycle, independent of busy and of writes.

Test Plan:
1. Release rst, hold clear=0 -> busy=1 for exactly 768 cycles, then 0. Afterwards rect_read_addr={16'd5,16'd7} gives 0000. With BORDER_ROCK=1, {0,0} and {31,23} give 0010 and {1,1} gives 0000.
2. busy=0, drive rect_write={16'd15,16'd15,4'b0001} for one cycle -> rect_read_data at {15,15} is 0001 from the next cycle. Driving pix_x=480, pix_y=480 gives pix_cell=0001 one cycle later, with pix_x_d=480 and pix_y_d=480.
3. Out of range: rect_read_addr={16'hFFFF,16'd3} -> 0010. {16'd32,16'd0} -> 0010. {16'd0,16'd24} -> 0010. Writing func 0100 to {16'd40,16'd2} leaves every cell unchanged.
4. During the sweep, write {3,3,0100} -> ignored; {3,3} reads 0000 after busy falls. Pulse clear at sweep index 400 -> busy stays high 768 cycles from the pulse.
5. Write SNACK 0100 to {10,4} while the read address is {10,4} in the same cycle -> old value 0000 that cycle, 0100 the next.
6. pix_x=1100, pix_y=100 -> pix_cell=0000. Assert rst mid-frame -> pix_cell, pix_x_d and pix_y_d are 0 immediately, and busy=1.
